song_select_ctrl: RTL and testbench

SONG_SELECT_CTRL -- requirements
Module: song_select_ctrl

---
 rtl/song_select_ctrl.sv | 134 +++++++++++++
 tb/tb_song_select_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/song_select_ctrl.sv
// Song-select controller.
// Synchronizes and debounces three raw push-buttons, turns their stable rising edges into
// one-cycle press events, and runs an IDLE/SELECT/LOCKED FSM that steps the selected song
// index and confirms a choice.
//
// Ports:
//   clk        - system clock, all state changes on its rising edge
//   rst        - asynchronous active-high reset
//   en         - high while the song-select screen is displayed
//   btn_up     - raw push-button, active-high
//   btn_down   - raw push-button, active-high
//   btn_ok     - raw push-button, active-high
//   song       - selected song index (3 = top row, 0 = bottom row), registered
//   selecting  - high only while in SELECT, registered
//   song_start - one-cycle pulse when a song is confirmed, registered
module song_select_ctrl #(
  parameter logic [19:0] DB_MAX = 20'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  output logic [1:0] song,
  output logic       selecting,
  output logic       song_start
);

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StLocked
  } state_e;

  // Bit order everywhere: [0] = up, [1] = down, [2] = ok.
  logic [2:0] raw;
  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic [2:0] stable;
  logic [2:0] stable_dly;
  logic [2:0] press;
  state_e     state;

  assign raw = {btn_ok, btn_down, btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // One debouncer per button: the stable level only follows the synchronized value after it
  // has differed for DB_MAX consecutive cycles; any return to the stable level restarts it.
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [19:0] cnt;
    logic        lvl;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_b[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_MAX - 20'd1) begin
        lvl <= sync_b[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end

    assign stable[i] = lvl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_dly <= '0;
    end else begin
      stable_dly <= stable;
    end
  end

  // Press event on 0->1 of the stable level only; releases are silent.
  assign press = stable & ~stable_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      song       <= 2'd3;
      selecting  <= 1'b0;
      song_start <= 1'b0;
    end else begin
      song_start <= 1'b0;
      case (state)
        StIdle: begin
          if (en) begin
            state     <= StSelect;
            selecting <= 1'b1;
          end
        end
        StSelect: begin
          // Leaving the screen outranks every press; ok outranks up/down.
          if (!en) begin
            state     <= StIdle;
            selecting <= 1'b0;
          end else if (press[2]) begin
            state      <= StLocked;
            selecting  <= 1'b0;
            song_start <= 1'b1;
          end else if (press[0] && !press[1]) begin
            song <= song + 2'd1;
          end else if (press[1] && !press[0]) begin
            song <= song - 2'd1;
          end
        end
        StLocked: begin
          if (!en) begin
            state <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          selecting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_select_ctrl.sv
// Self-checking bench for song_select_ctrl with DB_MAX = 4.
// Stimulus pushes the expected output tuple (and, where timing matters, the expected cycle)
// into a queue; a monitor pops one entry each time {song, selecting, song_start} changes.
module tb_song_select_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_ok = 1'b0;
  logic [1:0] song;
  logic       selecting;
  logic       song_start;

  int   cyc = 0;
  logic stim_done = 1'b0;
  int   tests = 0;
  int   fails = 0;

  typedef struct packed {
    logic [1:0] song;
    logic       sel;
    logic       start;
    int         cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  song_select_ctrl #(
    .DB_MAX(20'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_ok    (btn_ok),
    .song      (song),
    .selecting (selecting),
    .song_start(song_start)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // c < 0 means the arrival cycle is not checked.
  task automatic expect_out(input string nm, input logic [1:0] s, input logic sl,
                            input logic st, input int c);
    exp_t e;
    e.song  = s;
    e.sel   = sl;
    e.start = st;
    e.cyc   = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Inputs change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // m = {ok, down, up}; hold long enough to debounce, then wait out the release.
  task automatic press(input logic [2:0] m, input int hold);
    {btn_ok, btn_down, btn_up} = m;
    step(hold);
    {btn_ok, btn_down, btn_up} = 3'b000;
    step(10);
  endtask

  // Stimulus
  initial begin
    expect_out("reset", 2'd3, 1'b0, 1'b0, -1);
    step(3);
    rst = 1'b0;
    step(2);

    expect_out("en_select", 2'd3, 1'b1, 1'b0, cyc + 1);
    en = 1'b1;
    step(4);

    expect_out("up_wrap", 2'd0, 1'b1, 1'b0, cyc + 7);
    press(3'b001, 8);
    expect_out("up_second", 2'd1, 1'b1, 1'b0, cyc + 7);
    press(3'b001, 8);
    expect_out("down_1to0", 2'd0, 1'b1, 1'b0, cyc + 7);
    press(3'b010, 8);
    expect_out("down_wrap", 2'd3, 1'b1, 1'b0, cyc + 7);
    press(3'b010, 8);
    // Up and down together: no output change expected.
    press(3'b011, 8);
    expect_out("down_3to2", 2'd2, 1'b1, 1'b0, cyc + 7);
    press(3'b010, 8);

    // Bounce: 2 cycles high, 2 low, never stable long enough.
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      step(2);
    end
    btn_up = 1'b0;
    step(10);

    expect_out("ok_pulse", 2'd2, 1'b0, 1'b1, cyc + 7);
    expect_out("ok_pulse_end", 2'd2, 1'b0, 1'b0, cyc + 8);
    press(3'b100, 8);
    // Locked: presses ignored.
    press(3'b001, 8);
    press(3'b010, 8);
    en = 1'b0;
    step(4);
    expect_out("reenter", 2'd2, 1'b1, 1'b0, cyc + 1);
    en = 1'b1;
    step(4);

    expect_out("en_drop", 2'd2, 1'b0, 1'b0, cyc + 1);
    en = 1'b0;
    step(4);
    expect_out("reenter2", 2'd2, 1'b1, 1'b0, cyc + 1);
    en = 1'b1;
    step(4);

    // Reset in the middle of an ok debounce.
    btn_ok = 1'b1;
    step(2);
    expect_out("rst_abort", 2'd3, 1'b0, 1'b0, -1);
    rst    = 1'b1;
    en     = 1'b0;
    btn_ok = 1'b0;
    step(2);
    rst = 1'b0;
    step(15);

    expect_out("resume", 2'd3, 1'b1, 1'b0, cyc + 1);
    en = 1'b1;
    step(5);

    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    logic [3:0] last;
    logic [3:0] cur;
    logic [3:0] want;
    exp_t       e;
    string      nm;
    last = 4'bxxxx;
    forever begin
      @(negedge clk);
      if (stim_done) break;
      cur = {song, selecting, song_start};
      if (cur !== last) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_change: got song=%0d selecting=%0b song_start=%0b at cycle %0d, required no change",
                   song, selecting, song_start, cyc);
        end else begin
          e    = exp_q.pop_front();
          nm   = name_q.pop_front();
          want = {e.song, e.sel, e.start};
          tests++;
          if (cur !== want) begin
            fails++;
            $display("FAIL %s: got song=%0d selecting=%0b song_start=%0b, required song=%0d selecting=%0b song_start=%0b",
                     nm, song, selecting, song_start, e.song, e.sel, e.start);
          end
          if (e.cyc >= 0) begin
            tests++;
            if (cyc != e.cyc) begin
              fails++;
              $display("FAIL %s_cycle: got cycle %0d, required cycle %0d", nm, cyc, e.cyc);
            end
          end
        end
      end
      last = cur;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d still queued (next %s), required 0",
               exp_q.size(), name_q[0]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus by cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
